// File: rtl/issue_queue_n.sv
// rtl/issue_queue_n.sv - collapsing issue queue, oldest-first select, CDB wakeup (ISSUE_CDB_WAKEUP_BYPASS_EN adds same-cycle wakeup)
module issue_queue_n #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int PL_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       disp_en,
  input  logic [PL_W-1:0]            disp_payload,
  input  logic [TAG_W-1:0]           disp_op1_tag,
  input  logic [TAG_W-1:0]           disp_op2_tag,
  input  logic                       disp_op1_vld,
  input  logic                       disp_op2_vld,
  input  logic [DATA_W-1:0]          disp_op1_data,
  input  logic [DATA_W-1:0]          disp_op2_data,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       flush,
  input  logic                       issue_ready,
  output logic                       issue_valid,
  output logic [PL_W-1:0]            issue_payload,
  output logic [DATA_W-1:0]          issue_op1,
  output logic [DATA_W-1:0]          issue_op2,
  output logic [$clog2(DEPTH)-1:0]   issue_idx,
  output logic                       queue_full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld_q, v1_q, v2_q;
  logic [PL_W-1:0]   pl_q [DEPTH];
  logic [TAG_W-1:0]  t1_q [DEPTH];
  logic [TAG_W-1:0]  t2_q [DEPTH];
  logic [DATA_W-1:0] d1_q [DEPTH];
  logic [DATA_W-1:0] d2_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q;

  logic [DEPTH-1:0]  vld_d, v1_d, v2_d;
  logic [PL_W-1:0]   pl_d [DEPTH];
  logic [TAG_W-1:0]  t1_d [DEPTH];
  logic [TAG_W-1:0]  t2_d [DEPTH];
  logic [DATA_W-1:0] d1_d [DEPTH];
  logic [DATA_W-1:0] d2_d [DEPTH];
  logic [CNT_W-1:0]  cnt_d;

  logic [DEPTH-1:0]  hit1, hit2, rdy, fired, shift;
  logic [DEPTH-1:0]  c1v, c2v;
  logic [DATA_W-1:0] c1d [DEPTH];
  logic [DATA_W-1:0] c2d [DEPTH];
  logic              sel_vld, fire, accept, dh1, dh2, acc;
  logic [IDX_W-1:0]  sel_idx;

  // Tag match against the broadcast, and the post-capture view of each slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = cdb_valid && vld_q[i] && !v1_q[i] && (t1_q[i] == cdb_tag);
      hit2[i] = cdb_valid && vld_q[i] && !v2_q[i] && (t2_q[i] == cdb_tag);
      c1v[i]  = v1_q[i] | hit1[i];
      c2v[i]  = v2_q[i] | hit2[i];
      c1d[i]  = hit1[i] ? cdb_data : d1_q[i];
      c2d[i]  = hit2[i] ? cdb_data : d2_q[i];
`ifdef ISSUE_CDB_WAKEUP_BYPASS_EN
      rdy[i]  = vld_q[i] && c1v[i] && c2v[i];
`else
      rdy[i]  = vld_q[i] && v1_q[i] && v2_q[i];
`endif
    end
  end

  // Highest index is the oldest entry, so the last hit in the scan wins
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    issue_valid   = sel_vld;
    issue_idx     = sel_idx;
    issue_payload = '0;
    issue_op1     = '0;
    issue_op2     = '0;
    if (sel_vld) begin
      issue_payload = pl_q[sel_idx];
`ifdef ISSUE_CDB_WAKEUP_BYPASS_EN
      issue_op1     = c1d[sel_idx];
      issue_op2     = c2d[sel_idx];
`else
      issue_op1     = d1_q[sel_idx];
      issue_op2     = d2_q[sel_idx];
`endif
    end
  end

  assign fire       = sel_vld && issue_ready;
  assign queue_full = &vld_q;
  assign count      = cnt_q;
  // A full queue still takes a dispatch in a fire cycle: the freed slot makes room
  assign accept     = disp_en && (!queue_full || fire);
  assign dh1        = cdb_valid && !disp_op1_vld && (disp_op1_tag == cdb_tag);
  assign dh2        = cdb_valid && !disp_op2_vld && (disp_op2_tag == cdb_tag);

  always_comb begin
    acc = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fired[i] = fire && (sel_idx == IDX_W'(i));
      acc      = acc | !vld_q[i] | fired[i];
      shift[i] = acc;
    end
  end

  always_comb begin
    if (shift[0]) begin
      vld_d[0] = accept;
      pl_d[0]  = disp_payload;
      t1_d[0]  = disp_op1_tag;
      t2_d[0]  = disp_op2_tag;
      v1_d[0]  = disp_op1_vld | dh1;
      v2_d[0]  = disp_op2_vld | dh2;
      d1_d[0]  = dh1 ? cdb_data : disp_op1_data;
      d2_d[0]  = dh2 ? cdb_data : disp_op2_data;
    end else begin
      vld_d[0] = vld_q[0];
      pl_d[0]  = pl_q[0];
      t1_d[0]  = t1_q[0];
      t2_d[0]  = t2_q[0];
      v1_d[0]  = c1v[0];
      v2_d[0]  = c2v[0];
      d1_d[0]  = c1d[0];
      d2_d[0]  = c2d[0];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (shift[i]) begin
        vld_d[i] = vld_q[i-1] && !fired[i-1];
        pl_d[i]  = pl_q[i-1];
        t1_d[i]  = t1_q[i-1];
        t2_d[i]  = t2_q[i-1];
        v1_d[i]  = c1v[i-1];
        v2_d[i]  = c2v[i-1];
        d1_d[i]  = c1d[i-1];
        d2_d[i]  = c2d[i-1];
      end else begin
        vld_d[i] = vld_q[i];
        pl_d[i]  = pl_q[i];
        t1_d[i]  = t1_q[i];
        t2_d[i]  = t2_q[i];
        v1_d[i]  = c1v[i];
        v2_d[i]  = c2v[i];
        d1_d[i]  = c1d[i];
        d2_d[i]  = c2d[i];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      v1_q  <= '0;
      v2_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pl_q[i] <= '0;
        t1_q[i] <= '0;
        t2_q[i] <= '0;
        d1_q[i] <= '0;
        d2_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
      v1_q  <= '0;
      v2_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        pl_q[i] <= pl_d[i];
        t1_q[i] <= t1_d[i];
        t2_q[i] <= t2_d[i];
        d1_q[i] <= d1_d[i];
        d2_q[i] <= d2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_n.sv
// tb/tb_issue_queue_n.sv - vector table, directed corners and random run against a slot-level reference model
module tb_issue_queue_n;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int PL_W   = 16;
`ifdef ISSUE_CDB_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_en;
  logic [PL_W-1:0]   disp_payload;
  logic [TAG_W-1:0]  disp_op1_tag, disp_op2_tag;
  logic              disp_op1_vld, disp_op2_vld;
  logic [DATA_W-1:0] disp_op1_data, disp_op2_data;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              issue_ready;
  logic              issue_valid;
  logic [PL_W-1:0]   issue_payload;
  logic [DATA_W-1:0] issue_op1, issue_op2;
  logic [1:0]        issue_idx;
  logic              queue_full;
  logic [2:0]        count;

  issue_queue_n #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .PL_W(PL_W)) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .disp_payload(disp_payload),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
    .disp_op1_vld(disp_op1_vld), .disp_op2_vld(disp_op2_vld),
    .disp_op1_data(disp_op1_data), .disp_op2_data(disp_op2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_payload(issue_payload), .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_idx(issue_idx), .queue_full(queue_full), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic [PL_W-1:0]   pl;
    logic [TAG_W-1:0]  t1, t2;
    logic              v1, v2;
    logic [DATA_W-1:0] d1, d2;
  } ent_t;

  typedef struct {
    logic            de;
    logic [PL_W-1:0] pl;
    logic            ir;
    int              e_cnt;
    logic            e_full;
    logic            e_iv;
    int              e_idx;
    logic [PL_W-1:0] e_pl;
  } vec_t;

  ent_t m [DEPTH];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t empty_ent();
    ent_t e;
    e.vld = 1'b0; e.pl = '0; e.t1 = '0; e.t2 = '0;
    e.v1 = 1'b0; e.v2 = 1'b0; e.d1 = '0; e.d2 = '0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = empty_ent();
  endtask

  // Oldest (highest slot) entry whose operands are available, with optional same-cycle wakeup
  task automatic model_comb(output logic iv, output int sel, output logic [PL_W-1:0] pl,
                            output logic [DATA_W-1:0] o1, output logic [DATA_W-1:0] o2);
    logic b1, b2;
    iv = 1'b0; sel = 0; pl = '0; o1 = '0; o2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      b1 = BYP && cdb_valid && !m[i].v1 && (m[i].t1 == cdb_tag);
      b2 = BYP && cdb_valid && !m[i].v2 && (m[i].t2 == cdb_tag);
      if (m[i].vld && (m[i].v1 || b1) && (m[i].v2 || b2)) begin
        iv = 1'b1; sel = i; pl = m[i].pl;
        o1 = b1 ? cdb_data : m[i].d1;
        o2 = b2 ? cdb_data : m[i].d2;
      end
    end
  endtask

  task automatic model_next();
    ent_t c [DEPTH];
    ent_t n [DEPTH];
    ent_t d;
    logic iv, fire, full, acc, sh;
    int sel;
    logic [PL_W-1:0] pl;
    logic [DATA_W-1:0] o1, o2;
    model_comb(iv, sel, pl, o1, o2);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].vld = 1'b0;
      return;
    end
    full = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (!m[i].vld) full = 1'b0;
    fire = iv && issue_ready;
    acc  = disp_en && (!full || fire);
    for (int i = 0; i < DEPTH; i++) begin
      c[i] = m[i];
      if (c[i].vld && cdb_valid && !c[i].v1 && c[i].t1 == cdb_tag) begin c[i].v1 = 1'b1; c[i].d1 = cdb_data; end
      if (c[i].vld && cdb_valid && !c[i].v2 && c[i].t2 == cdb_tag) begin c[i].v2 = 1'b1; c[i].d2 = cdb_data; end
    end
    d.vld = 1'b1; d.pl = disp_payload; d.t1 = disp_op1_tag; d.t2 = disp_op2_tag;
    d.v1 = disp_op1_vld; d.v2 = disp_op2_vld; d.d1 = disp_op1_data; d.d2 = disp_op2_data;
    if (cdb_valid && !d.v1 && d.t1 == cdb_tag) begin d.v1 = 1'b1; d.d1 = cdb_data; end
    if (cdb_valid && !d.v2 && d.t2 == cdb_tag) begin d.v2 = 1'b1; d.d2 = cdb_data; end
    for (int i = 0; i < DEPTH; i++) begin
      sh = 1'b0;
      for (int j = i; j < DEPTH; j++) if (!m[j].vld || (fire && j == sel)) sh = 1'b1;
      if (!sh) n[i] = c[i];
      else if (i == 0) n[i] = acc ? d : empty_ent();
      else begin
        n[i] = c[i-1];
        if (!m[i-1].vld || (fire && sel == i-1)) n[i].vld = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) m[i] = n[i];
  endtask

  // Called at a falling edge with inputs driven; compares, advances the model, returns at the next falling edge
  task automatic step();
    logic iv;
    int sel, n;
    logic [PL_W-1:0] pl;
    logic [DATA_W-1:0] o1, o2;
    #2;
    model_comb(iv, sel, pl, o1, o2);
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].vld) n++;
    chk("m_valid", issue_valid, iv);
    chk("m_idx", issue_idx, sel);
    chk("m_payload", issue_payload, pl);
    chk("m_op1", issue_op1, o1);
    chk("m_op2", issue_op2, o2);
    chk("m_count", count, n);
    chk("m_full", queue_full, n == DEPTH);
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    disp_en = 0; disp_payload = '0; disp_op1_tag = '0; disp_op2_tag = '0;
    disp_op1_vld = 0; disp_op2_vld = 0; disp_op1_data = '0; disp_op2_data = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; flush = 0; issue_ready = 0;
  endtask

  task automatic disp(input logic [PL_W-1:0] pl, input logic [TAG_W-1:0] t1, input logic v1,
                      input logic [DATA_W-1:0] d1, input logic [TAG_W-1:0] t2, input logic v2,
                      input logic [DATA_W-1:0] d2);
    disp_en = 1; disp_payload = pl;
    disp_op1_tag = t1; disp_op1_vld = v1; disp_op1_data = d1;
    disp_op2_tag = t2; disp_op2_vld = v2; disp_op2_data = d2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  vec_t tv [13];

  initial begin
    tv[0]  = '{1, 16'hA1, 0, 0, 0, 0, 0, 16'h0};
    tv[1]  = '{1, 16'hA2, 0, 1, 0, 1, 0, 16'hA1};
    tv[2]  = '{1, 16'hA3, 0, 2, 0, 1, 1, 16'hA1};
    tv[3]  = '{1, 16'hA4, 0, 3, 0, 1, 2, 16'hA1};
    tv[4]  = '{1, 16'hA5, 0, 4, 1, 1, 3, 16'hA1};
    tv[5]  = '{0, 16'h00, 0, 4, 1, 1, 3, 16'hA1};
    tv[6]  = '{1, 16'hA6, 1, 4, 1, 1, 3, 16'hA1};
    tv[7]  = '{0, 16'h00, 0, 4, 1, 1, 3, 16'hA2};
    tv[8]  = '{0, 16'h00, 1, 4, 1, 1, 3, 16'hA2};
    tv[9]  = '{0, 16'h00, 1, 3, 0, 1, 3, 16'hA3};
    tv[10] = '{0, 16'h00, 1, 2, 0, 1, 3, 16'hA4};
    tv[11] = '{0, 16'h00, 1, 1, 0, 1, 3, 16'hA6};
    tv[12] = '{0, 16'h00, 0, 0, 0, 0, 0, 16'h0};

    do_reset();
    chk("rst_valid", issue_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", queue_full, 0);

    // Fill to full, drop a 5th dispatch, dispatch while firing when full, then drain
    for (int k = 0; k < 13; k++) begin
      set_idle();
      if (tv[k].de) disp(tv[k].pl, '0, 1, {16'h0, tv[k].pl}, '0, 1, {16'hFFFF, ~tv[k].pl});
      issue_ready = tv[k].ir;
      #1;
      chk($sformatf("tv%0d_count", k), count, tv[k].e_cnt);
      chk($sformatf("tv%0d_full", k), queue_full, tv[k].e_full);
      chk($sformatf("tv%0d_valid", k), issue_valid, tv[k].e_iv);
      chk($sformatf("tv%0d_idx", k), issue_idx, tv[k].e_idx);
      chk($sformatf("tv%0d_payload", k), issue_payload, tv[k].e_pl);
      step();
    end

    // Ready entry between two waiting ones: it issues out of order and the hole collapses
    do_reset();
    set_idle(); disp(16'h40, 6'h11, 0, 0, 6'h00, 1, 32'h2); step();
    set_idle(); disp(16'h41, 6'h00, 1, 32'h3, 6'h00, 1, 32'h4); step();
    set_idle(); disp(16'h42, 6'h00, 1, 32'h5, 6'h12, 0, 0); step();
    set_idle(); step();
    set_idle(); issue_ready = 1; #1;
    chk("ooo_idx", issue_idx, 2);
    chk("ooo_payload", issue_payload, 16'h41);
    step();
    set_idle(); issue_ready = 1; cdb(6'h12, 32'h55); #1;
    chk("ooo_wake_c_valid", issue_valid, BYP);
    step();
    set_idle(); issue_ready = 1; #1;
    chk("ooo_count", count, BYP ? 1 : 2);
    chk("ooo_c_valid", issue_valid, !BYP);
`ifndef ISSUE_CDB_WAKEUP_BYPASS_EN
    chk("ooo_c_idx", issue_idx, 2);
    chk("ooo_c_payload", issue_payload, 16'h42);
    chk("ooo_c_op2", issue_op2, 32'h55);
`endif
    step();
    set_idle(); issue_ready = 1; cdb(6'h11, 32'h66); #1;
    chk("ooo_wake_a_valid", issue_valid, BYP);
`ifdef ISSUE_CDB_WAKEUP_BYPASS_EN
    chk("ooo_a_idx", issue_idx, 3);
    chk("ooo_a_op1", issue_op1, 32'h66);
`endif
    step();
    set_idle(); issue_ready = 1; #1;
    chk("ooo_a_late_valid", issue_valid, !BYP);
`ifndef ISSUE_CDB_WAKEUP_BYPASS_EN
    chk("ooo_a_idx", issue_idx, 3);
    chk("ooo_a_payload", issue_payload, 16'h40);
    chk("ooo_a_op1", issue_op1, 32'h66);
`endif
    step();

    // Wakeup on tag 0x15 while the entry is shifting
    do_reset();
    set_idle(); disp(16'h77, 6'h15, 0, 0, 6'h00, 1, 32'h2); step();
    set_idle(); issue_ready = 1; cdb(6'h15, 32'hDEADBEEF); #1;
    chk("wake_same_valid", issue_valid, BYP);
`ifdef ISSUE_CDB_WAKEUP_BYPASS_EN
    chk("wake_same_op1", issue_op1, 32'hDEADBEEF);
`endif
    step();
    set_idle(); issue_ready = 1; #1;
    chk("wake_next_valid", issue_valid, !BYP);
`ifndef ISSUE_CDB_WAKEUP_BYPASS_EN
    chk("wake_next_idx", issue_idx, 1);
    chk("wake_next_op1", issue_op1, 32'hDEADBEEF);
`endif
    step();

    // Capture into an operand being dispatched in the broadcast cycle
    do_reset();
    set_idle(); disp(16'h88, 6'h00, 1, 32'h1, 6'h07, 0, 0); cdb(6'h07, 32'h1234); step();
    set_idle(); #1;
    chk("disp_cap_valid", issue_valid, 1);
    chk("disp_cap_idx", issue_idx, 0);
    chk("disp_cap_op2", issue_op2, 32'h1234);
    step();

    // Flush beats dispatch and CDB
    set_idle(); disp(16'h99, 6'h00, 1, 1, 6'h00, 1, 2); cdb(6'h07, 32'h5); flush = 1; step();
    set_idle(); #1;
    chk("flush_count", count, 0);
    chk("flush_valid", issue_valid, 0);
    chk("flush_full", queue_full, 0);
    step();

    // Asynchronous reset in mid-cycle
    set_idle(); disp(16'hAA, 0, 1, 1, 0, 1, 2); step();
    set_idle(); disp(16'hAB, 0, 1, 3, 0, 1, 4); step();
    set_idle(); disp(16'hAC, 0, 1, 5, 0, 1, 6); issue_ready = 1;
    #2; rst_n = 0; #1;
    chk("arst_valid", issue_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_full", queue_full, 0);
    chk("arst_payload", issue_payload, 0);
    chk("arst_op1", issue_op1, 0);
    chk("arst_op2", issue_op2, 0);
    chk("arst_idx", issue_idx, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    set_idle(); disp(16'hAD, 0, 1, 7, 0, 1, 8); step();
    set_idle(); #1;
    chk("post_rst_idx", issue_idx, 0);
    chk("post_rst_payload", issue_payload, 16'hAD);
    step();

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      disp_en       = ($urandom_range(0, 9) < 7);
      disp_payload  = PL_W'($urandom);
      disp_op1_tag  = TAG_W'($urandom_range(0, 3));
      disp_op2_tag  = TAG_W'($urandom_range(0, 3));
      disp_op1_vld  = $urandom_range(0, 1) == 1;
      disp_op2_vld  = $urandom_range(0, 1) == 1;
      disp_op1_data = $urandom;
      disp_op2_data = $urandom;
      cdb_valid     = ($urandom_range(0, 9) < 4);
      cdb_tag       = TAG_W'($urandom_range(0, 3));
      cdb_data      = $urandom;
      flush         = ($urandom_range(0, 49) == 0);
      issue_ready   = ($urandom_range(0, 9) < 5);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
